// File: rtl/sha256_mmio_pkg.sv
// ---------------------------------------------------------------------------
// sha256_mmio_pkg
// Shared definitions for the SHA-256 MMIO bus master: the sequencing state
// enum, the accelerator register-window offsets and the word counts of a
// block and of a digest.
// No ports (package).
// ---------------------------------------------------------------------------
package sha256_mmio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_RDY,
    ST_WR_DATA,
    ST_WR_CLR,
    ST_WR_CTRL,
    ST_POLL_VLD,
    ST_RD_HASH,
    ST_DONE
  } state_e;

  localparam logic [7:0] CTRL_OFF  = 8'h00;
  localparam logic [7:0] DATA_OFF  = 8'h08;
  localparam logic [7:0] VALID_OFF = 8'h88;
  localparam logic [7:0] HASH_OFF  = 8'h90;

  localparam int NUM_DATA_WORDS = 16;
  localparam int NUM_HASH_WORDS = 8;

  // Registers are spaced 8 bytes apart; the largest offset (0xC8) fits in 8 bits.
  function automatic logic [7:0] wordOffset(input logic [7:0] base, input logic [3:0] idx);
    return base + {1'b0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_mmio_bus_port.sv
// ---------------------------------------------------------------------------
// sha256_mmio_bus_port
// Single-outstanding request/grant bus initiator. Latches one command from
// the sequencer, holds req/we/addr/wdata stable until grant, and reports
// completion (writes on grant, reads on the first rvalid at or after grant).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmdValid_i / cmdReady_o      command offer / port idle
//   cmdWe_i, cmdAddr_i, cmdWdata_i  command contents
//   cmdDone_o, cmdRdata_o        one-cycle completion pulse, read data [31:0]
//   req_o, gnt_i, we_o, addr_o, wdata_o, rvalid_i, rdata_i  bus side
// ---------------------------------------------------------------------------
module sha256_mmio_bus_port #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmdValid_i,
  output logic                  cmdReady_o,
  input  logic                  cmdWe_i,
  input  logic [ADDR_WIDTH-1:0] cmdAddr_i,
  input  logic [DATA_WIDTH-1:0] cmdWdata_i,
  output logic                  cmdDone_o,
  output logic [31:0]           cmdRdata_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  logic                  active_q;
  logic                  granted_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  unusedRdataHi;

  assign req_o      = active_q;
  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign cmdReady_o = !active_q;
  assign cmdRdata_o = rdata_i[31:0];
  assign unusedRdataHi = ^rdata_i[DATA_WIDTH-1:32];

  // An rvalid that arrives while no read is granted (e.g. a response to a
  // transaction abandoned by reset) is ignored because of the gating below.
  assign cmdDone_o = active_q &&
                     ((gnt_i && we_q) || ((gnt_i || granted_q) && rvalid_i));

  // Transaction register: idle -> request held until grant -> (reads) wait
  // for rvalid -> drop req the cycle after completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      granted_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (!active_q) begin
      if (cmdValid_i) begin
        active_q  <= 1'b1;
        granted_q <= 1'b0;
        we_q      <= cmdWe_i;
        addr_q    <= cmdAddr_i;
        wdata_q   <= cmdWdata_i;
      end
    end else if (cmdDone_o) begin
      active_q  <= 1'b0;
      granted_q <= 1'b0;
    end else if (gnt_i) begin
      granted_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sha256_mmio_master.sv
// ---------------------------------------------------------------------------
// sha256_mmio_master
// Hashes one 512-bit block per job by driving the SHA-256 accelerator's
// register window: poll ready, write 16 data words, write ctrl 0 then
// init/next, poll digest valid, read 8 hash words, return the digest.
// Optional macro SHA256_MMIO_TIMEOUT_EN bounds each poll phase to
// POLL_LIMIT reads and raises a sticky err_o when exceeded.
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   job_valid_i/job_ready_o, job_first_i, job_block_i   job request
//   dig_valid_o/dig_ready_i, digest_o     digest return
//   busy_o, err_o                         status
//   req_o, gnt_i, we_o, addr_o, wdata_o, rvalid_i, rdata_i   bus
// ---------------------------------------------------------------------------
module sha256_mmio_master
  import sha256_mmio_pkg::*;
#(
  parameter int unsigned               ADDR_WIDTH = 64,
  parameter int unsigned               DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR  = '0,
  parameter int unsigned               POLL_LIMIT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic                  job_first_i,
  input  logic [511:0]          job_block_i,
  output logic                  dig_valid_o,
  input  logic                  dig_ready_i,
  output logic [255:0]          digest_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  state_e                               state_q, state_d;
  logic [3:0]                           idx_q, idx_d;
  logic [NUM_DATA_WORDS-1:0][31:0]      block_q, block_d;
  logic                                 first_q, first_d;
  logic [NUM_HASH_WORDS-1:0][31:0]      digest_q, digest_d;

  logic        cmdValid, cmdWe, cmdReady, cmdDone;
  logic [7:0]  cmdOff;
  logic [31:0] cmdWdata, cmdRdata;
  logic        jobAccept;

`ifdef SHA256_MMIO_TIMEOUT_EN
  localparam logic [15:0] POLL_LIMIT16 = 16'(POLL_LIMIT);
  logic [15:0] pollCnt_q, pollCnt_d;
  logic        err_q, err_d;
  assign err_o = err_q;
`else
  logic [15:0] unusedPollLimit;
  assign unusedPollLimit = 16'(POLL_LIMIT);
  assign err_o = 1'b0;
`endif

  assign job_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign jobAccept   = job_valid_i && job_ready_o;
  assign dig_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign digest_o    = digest_q;

  sha256_mmio_bus_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bus (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmdValid_i (cmdValid),
    .cmdReady_o (cmdReady),
    .cmdWe_i    (cmdWe),
    .cmdAddr_i  (BASE_ADDR + ADDR_WIDTH'(cmdOff)),
    .cmdWdata_i (DATA_WIDTH'(cmdWdata)),
    .cmdDone_o  (cmdDone),
    .cmdRdata_o (cmdRdata),
    .req_o      (req_o),
    .gnt_i      (gnt_i),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .rvalid_i   (rvalid_i),
    .rdata_i    (rdata_i)
  );

  // Sequencer: each bus state keeps offering its command; the bus port only
  // latches it when idle, so a state that stays put simply reissues it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    block_d  = block_q;
    first_d  = first_q;
    digest_d = digest_q;
    cmdValid = 1'b0;
    cmdWe    = 1'b0;
    cmdOff   = CTRL_OFF;
    cmdWdata = '0;
`ifdef SHA256_MMIO_TIMEOUT_EN
    pollCnt_d = pollCnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (jobAccept) begin
          block_d = job_block_i;
          first_d = job_first_i;
          state_d = ST_POLL_RDY;
`ifdef SHA256_MMIO_TIMEOUT_EN
          pollCnt_d = '0;
`endif
        end
      end
      ST_POLL_RDY: begin
        cmdValid = 1'b1;
        cmdOff   = CTRL_OFF;
        if (cmdDone) begin
          if (cmdRdata[0]) begin
            idx_d   = '0;
            state_d = ST_WR_DATA;
          end
`ifdef SHA256_MMIO_TIMEOUT_EN
          else if (pollCnt_q + 16'd1 >= POLL_LIMIT16) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pollCnt_d = pollCnt_q + 16'd1;
          end
`endif
        end
      end
      ST_WR_DATA: begin
        cmdValid = 1'b1;
        cmdWe    = 1'b1;
        cmdOff   = wordOffset(DATA_OFF, idx_q);
        cmdWdata = block_q[idx_q];
        if (cmdDone) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(NUM_DATA_WORDS - 1)) state_d = ST_WR_CLR;
        end
      end
      // Clearing ctrl first guarantees the accelerator sees a rising edge on
      // init/next even if the previous job left the same bit set.
      ST_WR_CLR: begin
        cmdValid = 1'b1;
        cmdWe    = 1'b1;
        cmdOff   = CTRL_OFF;
        if (cmdDone) state_d = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        cmdValid = 1'b1;
        cmdWe    = 1'b1;
        cmdOff   = CTRL_OFF;
        cmdWdata = {30'b0, ~first_q, first_q};
        if (cmdDone) begin
          state_d = ST_POLL_VLD;
`ifdef SHA256_MMIO_TIMEOUT_EN
          pollCnt_d = '0;
`endif
        end
      end
      ST_POLL_VLD: begin
        cmdValid = 1'b1;
        cmdOff   = VALID_OFF;
        if (cmdDone) begin
          if (cmdRdata[0]) begin
            idx_d   = '0;
            state_d = ST_RD_HASH;
          end
`ifdef SHA256_MMIO_TIMEOUT_EN
          else if (pollCnt_q + 16'd1 >= POLL_LIMIT16) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pollCnt_d = pollCnt_q + 16'd1;
          end
`endif
        end
      end
      ST_RD_HASH: begin
        cmdValid = 1'b1;
        cmdOff   = wordOffset(HASH_OFF, idx_q);
        if (cmdDone) begin
          digest_d[idx_q[2:0]] = cmdRdata;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(NUM_HASH_WORDS - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (dig_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      block_q  <= '0;
      first_q  <= 1'b0;
      digest_q <= '0;
`ifdef SHA256_MMIO_TIMEOUT_EN
      pollCnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      block_q  <= block_d;
      first_q  <= first_d;
      digest_q <= digest_d;
`ifdef SHA256_MMIO_TIMEOUT_EN
      pollCnt_q <= pollCnt_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule
